// File: rtl/first_signal_round_ctrl.sv
// Round controller: arms on start, latches the first of a/b/c one-hot on y for a hold window.
// Optional per-channel win counters are built only when FSD_WIN_COUNT_EN is defined.
module first_signal_round_ctrl #(
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [2:0] y,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] win_cnt_a,
    output logic [7:0] win_cnt_b,
    output logic [7:0] win_cnt_c
);

    // state  | meaning
    // IDLE   | waiting for start, y=0
    // ARM    | waiting for all inputs low so a stuck-high input cannot win
    // LISTEN | first input high wins; timeout counter running
    // HOLD   | winner held on y for HOLD_CYCLES cycles
    typedef enum logic [1:0] {IDLE, ARM, LISTEN, HOLD} state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    ptr;

    logic [2:0] req;
    logic [2:0] rot;
    logic [1:0] off;
    logic [2:0] sum;
    logic [1:0] win_idx;
    logic [2:0] win_onehot;
    logic       win_hit;

    // Rotate requests so bit 0 is the channel at the priority pointer, then pick the lowest set bit.
    always_comb begin
        req = {c, b, a};
        rot = req;
        case (ptr)
            2'd1:    rot = {req[0], req[2], req[1]};
            2'd2:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
        off = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
        sum = {1'b0, ptr} + {1'b0, off};
        win_idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        win_onehot = 3'b001 << win_idx;
        win_hit = (state == LISTEN) && (req != 3'b000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            y        <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (req == 3'b000) begin
                        state   <= LISTEN;
                        tmo_cnt <= TMO_LOAD;
                    end
                end
                LISTEN: begin
                    // A win on the expiry cycle beats the timeout.
                    if (win_hit) begin
                        y        <= win_onehot;
                        done     <= 1'b1;
                        ptr      <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                        hold_cnt <= HOLD_LOAD;
                        state    <= HOLD;
                    end else if (tmo_cnt == TMO_ONE) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_ONE;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_ONE) begin
                        y     <= 3'b000;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FSD_WIN_COUNT_EN
    // Saturating counters; they step on the same edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_a <= 8'd0;
            win_cnt_b <= 8'd0;
            win_cnt_c <= 8'd0;
        end else if (win_hit) begin
            case (win_idx)
                2'd0:    if (win_cnt_a != 8'hFF) win_cnt_a <= win_cnt_a + 8'd1;
                2'd1:    if (win_cnt_b != 8'hFF) win_cnt_b <= win_cnt_b + 8'd1;
                default: if (win_cnt_c != 8'hFF) win_cnt_c <= win_cnt_c + 8'd1;
            endcase
        end
    end
`else
    assign win_cnt_a = 8'd0;
    assign win_cnt_b = 8'd0;
    assign win_cnt_c = 8'd0;
`endif

endmodule

// File: tb/tb_first_signal_round_ctrl.sv
// Directed bench for first_signal_round_ctrl: per-cycle vector table plus hand sequences
// for rotation, stuck inputs, mid-round reset and (with FSD_WIN_COUNT_EN) counter saturation.
module tb_first_signal_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic [2:0] y;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] win_cnt_a;
    logic [7:0] win_cnt_b;
    logic [7:0] win_cnt_c;

    int checks = 0;
    int errors = 0;

    first_signal_round_ctrl #(
        .HOLD_CYCLES   (8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .win_cnt_a(win_cnt_a),
        .win_cnt_b(win_cnt_b),
        .win_cnt_c(win_cnt_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       ia;
        logic       ib;
        logic       ic;
        logic [2:0] ey;
        logic       ebusy;
        logic       edone;
        logic       etmo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic ia, input logic ib, input logic ic);
        @(negedge clk);
        start = s;
        a = ia;
        b = ib;
        c = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic ia, input logic ib, input logic ic,
                       input logic [2:0] ey, input logic ebusy, input logic edone, input logic etmo);
        vec_t v;
        v.s = s; v.ia = ia; v.ib = ib; v.ic = ic;
        v.ey = ey; v.ebusy = ebusy; v.edone = edone; v.etmo = etmo;
        vecs.push_back(v);
    endtask

    // Full round from IDLE with the given {c,b,a} pattern applied on the first LISTEN cycle.
    task automatic do_round(input logic [2:0] inp, input logic [2:0] exp_y, input string name);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, inp[0], inp[1], inp[2]);
        check({name, "_y"}, {5'd0, y}, {5'd0, exp_y});
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check({name, "_busy_end"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        // b alone on the third LISTEN cycle, then 8-cycle hold
        add(1,0,0,0, 3'b000,1,0,0);
        add(0,0,0,0, 3'b000,1,0,0);
        add(0,0,0,0, 3'b000,1,0,0);
        add(0,0,0,0, 3'b000,1,0,0);
        add(0,0,1,0, 3'b010,1,1,0);
        for (int i = 0; i < 7; i++) add(0,1,1,1, 3'b010,1,0,0);
        add(0,0,0,0, 3'b000,0,0,0);
        // no input: timeout 4 cycles after LISTEN entry
        add(1,0,0,0, 3'b000,1,0,0);
        add(0,0,0,0, 3'b000,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0, 3'b000,1,0,0);
        add(0,0,0,0, 3'b000,0,0,1);
        add(0,0,0,0, 3'b000,0,0,0);
        // input on the expiry cycle wins, start during hold is dropped
        add(1,0,0,0, 3'b000,1,0,0);
        add(0,0,0,0, 3'b000,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,0, 3'b000,1,0,0);
        add(0,0,0,1, 3'b100,1,1,0);
        for (int i = 0; i < 7; i++) add(1,0,0,0, 3'b100,1,0,0);
        add(0,0,0,0, 3'b000,0,0,0);
        add(0,0,0,0, 3'b000,0,0,0);

        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_outputs", {2'd0, y, busy, done, timeout}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].ia, vecs[i].ib, vecs[i].ic);
            check($sformatf("vec%0d", i), {2'd0, y, busy, done, timeout},
                  {2'd0, vecs[i].ey, vecs[i].ebusy, vecs[i].edone, vecs[i].etmo});
        end

        // rotation: pointer is back at a after the table (b then c won)
        do_round(3'b111, 3'b001, "rot_a");
        do_round(3'b111, 3'b010, "rot_b");
        do_round(3'b111, 3'b100, "rot_c");

        // c stuck high through start keeps the controller in ARM, past the timeout length
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("stuck_arm", {4'd0, y, busy}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("stuck_a_wins", {5'd0, y}, 8'h01);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of HOLD after a b win (pointer would otherwise point at c)
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_rst_y", {5'd0, y}, 8'h02);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_y_busy", {4'd0, y, busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        do_round(3'b111, 3'b001, "rst_ptr");

`ifdef FSD_WIN_COUNT_EN
        check("cnt_b_pre", win_cnt_b, 8'd0);
        for (int r = 0; r < 256; r++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("cnt_a_sat", win_cnt_a, 8'd255);
`else
        check("cnt_a_tied", win_cnt_a, 8'd0);
        check("cnt_b_tied", win_cnt_b, 8'd0);
        check("cnt_c_tied", win_cnt_c, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
